// File: rtl/lif_neuron_if.sv
// lif_neuron_if: groups the neuron's enable, synapse inputs/weights and
// outputs into one bundle. The network side drives through the master
// modport, and the neuron attaches through the slave modport.
interface lif_neuron_if #(
    parameter int N_SYN   = 4,
    parameter int V_WIDTH = 8,
    parameter int W_WIDTH = 4
);
    logic                       en;
    logic [N_SYN-1:0]           spike_input;
    logic [N_SYN*W_WIDTH-1:0]   weight;
    logic                       spike_output;
    logic [V_WIDTH-1:0]         membrane;
    logic                       refractory;

    modport master (
        output en, spike_input, weight,
        input  spike_output, membrane, refractory
    );

    modport slave (
        input  en, spike_input, weight,
        output spike_output, membrane, refractory
    );
endinterface

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron.
// Each rising edge on a synapse input adds that synapse's weight to the
// membrane potential. The potential leaks by v >> LEAK_SHIFT every cycle.
// When the potential reaches the threshold, the neuron resets the potential
// to zero and emits a one-cycle spike. It then stays refractory for
// REFRACT_CYCLES cycles.
// Optional build macro LIF_ADAPT_THRESH_EN enables an adaptive threshold offset.
// The offset rises by ADAPT_STEP on every fire and decays by one on quiet
// integrate cycles.
module lif_neuron #(
    parameter int N_SYN          = 4,
    parameter int V_WIDTH        = 8,
    parameter int W_WIDTH        = 4,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int REFRACT_CYCLES = 4,
    parameter int ADAPT_STEP     = 8,
    parameter int ADAPT_MAX      = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    lif_neuron_if.slave   bus
);
    // Wide enough for v plus N_SYN full-scale weights without wrapping.
    localparam int SUM_W = V_WIDTH + $clog2(N_SYN) + 1;
    localparam int CNT_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;
    localparam logic [SUM_W-1:0] V_MAX    = SUM_W'((1 << V_WIDTH) - 1);
    localparam logic [SUM_W-1:0] THR      = SUM_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] CNT_INIT = (REFRACT_CYCLES > 0) ? CNT_W'(REFRACT_CYCLES - 1) : '0;

    if (THRESHOLD >= (1 << V_WIDTH) || ADAPT_STEP < 0 || ADAPT_MAX < 0) begin : g_param_check
        $error("lif_neuron: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        ST_INTEGRATE = 2'd0,
        ST_FIRE      = 2'd1,
        ST_REFRACT   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [N_SYN-1:0]   spike_q;
    logic [N_SYN-1:0]   rise_s;
    logic [V_WIDTH-1:0] v_q, v_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               spike_out_q, spike_out_d;
    logic               refr_q, refr_d;
    logic [SUM_W-1:0]   wsum_s, raw_s, sum_s, thr_s;

    assign rise_s = bus.spike_input & ~spike_q;

    // Add up the weights of every synapse that rose this cycle.
    always_comb begin
        wsum_s = '0;
        for (int i = 0; i < N_SYN; i++) begin
            if (rise_s[i]) begin
                wsum_s = wsum_s + SUM_W'(bus.weight[i*W_WIDTH +: W_WIDTH]);
            end else begin
                wsum_s = wsum_s;
            end
        end
    end

    // Apply the leak, add the input, and saturate so a large burst cannot wrap to a small value.
    always_comb begin
        raw_s = SUM_W'(v_q) - SUM_W'(v_q >> LEAK_SHIFT) + wsum_s;
        if (raw_s > V_MAX) begin
            sum_s = V_MAX;
        end else begin
            sum_s = raw_s;
        end
    end

`ifdef LIF_ADAPT_THRESH_EN
    localparam int OFF_W  = $clog2(ADAPT_MAX + 1);
    localparam int OFF_W1 = OFF_W + 1;
    localparam logic [OFF_W1-1:0] OFF_MAX  = OFF_W1'(ADAPT_MAX);
    localparam logic [OFF_W1-1:0] OFF_STEP = OFF_W1'(ADAPT_STEP);

    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [OFF_W1-1:0] off_inc_s;

    assign thr_s = THR + SUM_W'(offset_q);

    // A fire bumps the offset up, saturating at the ceiling. A quiet enabled integrate cycle decays it by one.
    always_comb begin
        off_inc_s = {1'b0, offset_q} + OFF_STEP;
        offset_d  = offset_q;
        if (state_q == ST_INTEGRATE && bus.en && sum_s >= thr_s) begin
            if (off_inc_s > OFF_MAX) begin
                offset_d = OFF_MAX[OFF_W-1:0];
            end else begin
                offset_d = off_inc_s[OFF_W-1:0];
            end
        end else if (state_q == ST_INTEGRATE && bus.en && rise_s == '0 && offset_q != '0) begin
            offset_d = offset_q - OFF_W'(1);
        end else begin
            offset_d = offset_q;
        end
    end

    // Register the adaptive threshold offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            offset_q <= '0;
        end else begin
            offset_q <= offset_d;
        end
    end
`else
    assign thr_s = THR;
`endif

    // Next-state logic for integrate, fire and refractory.
    // The output flags are registered from the current state, so they appear one cycle after the state.
    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_INTEGRATE: begin
                if (bus.en) begin
                    if (sum_s >= thr_s) begin
                        v_d     = '0;
                        state_d = ST_FIRE;
                    end else begin
                        v_d     = sum_s[V_WIDTH-1:0];
                        state_d = ST_INTEGRATE;
                    end
                end else begin
                    v_d     = v_q;
                    state_d = ST_INTEGRATE;
                end
            end
            ST_FIRE: begin
                v_d   = '0;
                cnt_d = CNT_INIT;
                if (REFRACT_CYCLES > 0) begin
                    state_d = ST_REFRACT;
                end else begin
                    state_d = ST_INTEGRATE;
                end
            end
            ST_REFRACT: begin
                v_d = '0;
                if (cnt_q == '0) begin
                    state_d = ST_INTEGRATE;
                    cnt_d   = cnt_q;
                end else begin
                    state_d = ST_REFRACT;
                    cnt_d   = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_INTEGRATE;
                v_d     = '0;
                cnt_d   = '0;
            end
        endcase
        spike_out_d = (state_q == ST_FIRE);
        refr_d      = (state_q == ST_REFRACT);
    end

    // State, membrane, counter, edge-detect history and output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_INTEGRATE;
            v_q         <= '0;
            cnt_q       <= '0;
            spike_q     <= '0;
            spike_out_q <= 1'b0;
            refr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            cnt_q       <= cnt_d;
            spike_q     <= bus.spike_input;
            spike_out_q <= spike_out_d;
            refr_q      <= refr_d;
        end
    end

    assign bus.spike_output = spike_out_q;
    assign bus.membrane     = v_q;
    assign bus.refractory   = refr_q;
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: scoreboard bench for lif_neuron. The stimulus tasks push the
// expected post-edge outputs into a queue, and a monitor pops and compares
// them after every rising clock edge.
// dut_a uses the default parameters. dut_b uses THRESHOLD=255 to exercise
// saturation of the internal sum.
module tb_lif_neuron;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lif_neuron_if #(.N_SYN(4), .V_WIDTH(8), .W_WIDTH(4)) bus_a ();
    lif_neuron_if #(.N_SYN(4), .V_WIDTH(8), .W_WIDTH(4)) bus_b ();

    lif_neuron #(
        .N_SYN(4), .V_WIDTH(8), .W_WIDTH(4), .THRESHOLD(200), .LEAK_SHIFT(3),
        .REFRACT_CYCLES(4), .ADAPT_STEP(8), .ADAPT_MAX(32)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    lif_neuron #(
        .N_SYN(4), .V_WIDTH(8), .W_WIDTH(4), .THRESHOLD(255), .LEAK_SHIFT(3),
        .REFRACT_CYCLES(4), .ADAPT_STEP(8), .ADAPT_MAX(32)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    typedef struct {
        bit         sel;
        logic [7:0] mem;
        logic       spk;
        logic       refr;
        string      tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Hand-computed membrane traces.
    int t1_mem [10] = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 7};
    int t2_mem [5]  = '{60, 53, 47, 42, 37};
    int t3_mem [18] = '{60, 53, 107, 94, 143, 126, 171, 150, 192, 168,
                        0, 0, 0, 0, 0, 0, 60, 53};
    int t4_mem [33] = '{60, 53, 107, 94, 143, 126, 171, 150, 192, 168,
                        207, 182, 220, 193, 229, 201, 236, 207, 242, 212,
                        246, 216, 249, 218, 251, 220, 253, 222, 254, 223,
                        0, 0, 0};

    task automatic step(input bit sel, input logic r, input logic e,
                        input logic [3:0] si, input logic [15:0] w,
                        input int mem, input logic spk, input logic refr,
                        input string tag);
        exp_t x;
        @(negedge clk);
        rst_n = r;
        if (sel) begin
            bus_b.en = e; bus_b.spike_input = si; bus_b.weight = w;
        end else begin
            bus_a.en = e; bus_a.spike_input = si; bus_a.weight = w;
        end
        x.sel = sel; x.mem = 8'(mem); x.spk = spk; x.refr = refr; x.tag = tag;
        sb_q.push_back(x);
    endtask

    // Monitor: compare outputs just after every rising edge that has an expectation pending.
    initial begin
        exp_t       x;
        logic [7:0] m;
        logic       s, f;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                if (x.sel) begin
                    m = bus_b.membrane; s = bus_b.spike_output; f = bus_b.refractory;
                end else begin
                    m = bus_a.membrane; s = bus_a.spike_output; f = bus_a.refractory;
                end
                n_cmp++;
                if (m !== x.mem || s !== x.spk || f !== x.refr) begin
                    n_bad++;
                    $display("FAIL %s: got mem=%0d spk=%b refr=%b, want mem=%0d spk=%b refr=%b",
                             x.tag, m, s, f, x.mem, x.spk, x.refr);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        rst_n = 1'b0;
        bus_a.en = 1'b0; bus_a.spike_input = 4'h0; bus_a.weight = 16'h0000;
        bus_b.en = 1'b0; bus_b.spike_input = 4'h0; bus_b.weight = 16'h0000;

        // Reset values
        step(1'b0, 1'b0, 1'b0, 4'h0, 16'h0000, 0, 1'b0, 1'b0, "reset_a");
        step(1'b1, 1'b0, 1'b0, 4'h0, 16'h0000, 0, 1'b0, 1'b0, "reset_b");

        // Single held rise on syn0 with weight 15: leak down to the floor of 7
        for (int i = 0; i < 10; i++)
            step(1'b0, 1'b1, 1'b1, 4'h1, 16'h000F, t1_mem[i], 1'b0, 1'b0, "single_rise_leak");
        step(1'b0, 1'b0, 1'b1, 4'h0, 16'hFFFF, 0, 1'b0, 1'b0, "sync_reset_1");

        // All inputs raised and held: only the edge contributes
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b1, 1'b1, 4'hF, 16'hFFFF, t2_mem[i], 1'b0, 1'b0, "held_high_once");
        step(1'b0, 1'b0, 1'b1, 4'h0, 16'hFFFF, 0, 1'b0, 1'b0, "sync_reset_2");

        // Toggle every cycle: fire on the 6th rise, then spike, then 4 refractory cycles, then resume
        for (int s = 0; s < 18; s++)
            step(1'b0, 1'b1, 1'b1, (s % 2 == 0) ? 4'hF : 4'h0, 16'hFFFF, t3_mem[s],
                 (s == 11), (s >= 12 && s <= 15), "toggle_fire_refract");
        step(1'b0, 1'b0, 1'b1, 4'h0, 16'hFFFF, 0, 1'b0, 1'b0, "sync_reset_3");

        // Build membrane to 100, then freeze with en=0 while inputs toggle
        step(1'b0, 1'b1, 1'b1, 4'hF, 16'hFFFF, 60, 1'b0, 1'b0, "build_100");
        step(1'b0, 1'b1, 1'b1, 4'h0, 16'hFFFF, 53, 1'b0, 1'b0, "build_100");
        step(1'b0, 1'b1, 1'b1, 4'hF, 16'h8FFF, 100, 1'b0, 1'b0, "build_100");
        for (int s = 3; s < 13; s++)
            step(1'b0, 1'b1, 1'b0, (s % 2 == 0) ? 4'hF : 4'h0, 16'h8FFF, 100, 1'b0, 1'b0, "en_low_hold");
        step(1'b0, 1'b1, 1'b1, 4'hF, 16'h8FFF, 88, 1'b0, 1'b0, "en_resume_no_rise");
        step(1'b0, 1'b1, 1'b1, 4'h0, 16'h8FFF, 77, 1'b0, 1'b0, "en_resume_leak");
        step(1'b0, 1'b0, 1'b1, 4'h0, 16'hFFFF, 0, 1'b0, 1'b0, "sync_reset_4");

        // Fire again, then apply reset asynchronously during the refractory period
        for (int s = 0; s < 13; s++)
            step(1'b0, 1'b1, 1'b1, (s % 2 == 0) ? 4'hF : 4'h0, 16'hFFFF, t3_mem[s],
                 (s == 11), (s == 12), "refire_before_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bus_a.membrane !== 8'd0 || bus_a.spike_output !== 1'b0 || bus_a.refractory !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_refract: got mem=%0d spk=%b refr=%b, want mem=0 spk=0 refr=0",
                     bus_a.membrane, bus_a.spike_output, bus_a.refractory);
        end
        step(1'b0, 1'b0, 1'b1, 4'h0, 16'hFFFF, 0, 1'b0, 1'b0, "reset_held");
        step(1'b0, 1'b1, 1'b1, 4'hF, 16'hFFFF, 60, 1'b0, 1'b0, "after_reset_integrate");
        step(1'b0, 1'b1, 1'b1, 4'h0, 16'hFFFF, 53, 1'b0, 1'b0, "after_reset_integrate");

        // THRESHOLD=255: climb to 254, leak to 223, then 223-27+60=256 saturates to 255 and fires
        for (int s = 0; s < 33; s++)
            step(1'b1, 1'b1, 1'b1, (s % 2 == 0) ? 4'hF : 4'h0,
                 (s == 28) ? 16'hEFFF : 16'hFFFF, t4_mem[s],
                 (s == 31), (s == 32), "saturate_fire");

        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
Leaky integrate-and-fire neuron that consumes the spike outputs of N_SYN synapse stages, directly downstream of them.
- Each synapse rising edge adds a per-synapse weight to a membrane potential.
- The potential leaks geometrically every cycle.
- On crossing threshold the neuron emits a one-cycle spike and enters a refractory period.
- Its spike_output feeds the next layer of synapses in the oscillator network.

Parameters:
N_SYN, 4, number of synapse inputs
V_WIDTH, 8, membrane potential width (unsigned)
W_WIDTH, 4, per-synapse weight width (unsigned)
THRESHOLD, 200, firing threshold (must be < 2^V_WIDTH)
LEAK_SHIFT, 3, leak per cycle = v >> LEAK_SHIFT
REFRACT_CYCLES, 4, refractory length in cycles (0 allowed)
ADAPT_STEP, 8, threshold increase per fire (optional feature only)
ADAPT_MAX, 32, threshold offset ceiling (optional feature only)

Ports:
clk  input  1  single clock; all state on rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  integrate enable; low freezes state and membrane
spike_input  input  N_SYN  synapse spike levels, synchronous to clk
weight  input  N_SYN*W_WIDTH  weight i in bits [i*W_WIDTH +: W_WIDTH], static or clk-synchronous
spike_output  output  1  registered one-cycle fire pulse
membrane  output  V_WIDTH  current membrane potential
refractory  output  1  high while in REFRACT state

Behaviour:
- Reset (async, rst_n=0):
  - spike_output=0, membrane=0, refractory=0.
  - State=INTEGRATE, edge register spike_q=0, refractory counter=0, adapt offset=0.
- Edge detect: rise[i] = spike_input[i] & ~spike_q[i]. spike_q <= spike_input every cycle regardless of state or en. A level held high contributes once.
- States: INTEGRATE, FIRE, REFRACT.
- INTEGRATE with en=1:
  - sum = v - (v>>LEAK_SHIFT) + sum of weight[i] over rise[i].
  - Internal width V_WIDTH+$clog2(N_SYN)+1; saturate to 2^V_WIDTH-1.
  - If sum >= THRESHOLD: membrane<=0, state<=FIRE.
  - Else: membrane<=sum.
- INTEGRATE with en=0: membrane and state hold. Rises in that cycle are lost.
- FIRE: lasts exactly 1 cycle.
  - spike_output=1 in FIRE only, so the pulse appears the cycle after the crossing edge.
  - Membrane held 0, rises ignored.
  - Next state: REFRACT with counter=REFRACT_CYCLES-1, or INTEGRATE if REFRACT_CYCLES=0.
- REFRACT:
  - refractory=1, membrane held 0, rises ignored.
  - Counter decrements each cycle; leave to INTEGRATE after the cycle where counter==0, i.e. exactly REFRACT_CYCLES cycles.
  - en is ignored in FIRE and REFRACT; the sequence always completes.
- Latency: rise sampled at edge k updates membrane at edge k. Crossing at edge k gives spike_output high from edge k+1 to edge k+2.
- Leak floor: v < 2^LEAK_SHIFT does not decay further (v>>LEAK_SHIFT = 0).
- Reset asserted mid-FIRE or mid-REFRACT: immediate return to reset values, no residual pulse.

Optional Feature:
LIF_ADAPT_THRESH_EN
- Defined:
  - Effective threshold = THRESHOLD + offset; offset is a register of width $clog2(ADAPT_MAX+1).
  - Each entry to FIRE adds ADAPT_STEP to offset, saturating at ADAPT_MAX.
  - Each INTEGRATE cycle with en=1 and no rise decrements offset by 1, floor 0.
  - Offset resets to 0.
- Undefined: offset logic is absent; threshold is the fixed THRESHOLD.

Test Plan:
1. Single rise on syn0, weight0=15, others 0, en=1 -> membrane sequence 15,14,13,12,11,10,9,8,7,7 (settles at 7); spike_output stays 0.
2. All four weights=15, all inputs raised and held high -> membrane 60 once, then 53,47,42,... with no further additions (edge-only contribution).
3. All weights=15, all inputs toggled 1/0 every cycle from reset -> membrane after rises 60,107,143,171,192; 6th rise (207>=200) -> membrane 0, spike_output high exactly 1 cycle, then refractory high exactly 4 cycles with membrane 0 despite continued toggles; integration resumes from 0.
4. THRESHOLD=255, membrane driven to 250, all four rise with weight 15 -> internal 279 saturates to 255 >= 255 -> fires; no wrap to a small value.
5. en=0 for 10 cycles with membrane=100 and toggling inputs -> membrane stays 100, no spike. Separately, rst_n pulsed low during REFRACT -> all outputs 0 asynchronously and state INTEGRATE after release.
6. With LIF_ADAPT_THRESH_EN and scenario 3 stimulus -> after first fire offset=8 (threshold 208); second fire needs membrane >= 208 minus any decay; offset saturates at 32 after 4 rapid fires.
